// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
// Shared definitions for the gate sweep sequencer:
//   gs_state_t      - sequencer states (idle, settling, sampling, done)
//   GS_NUM_VEC      - number of input vectors for a 2-input gate
//   GS_TMR_W        - width of the settle down-counter
//   gs_reload_val() - timer reload value for a given settle length
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        GS_IDLE   = 2'd0,
        GS_SETTLE = 2'd1,
        GS_SAMPLE = 2'd2,
        GS_DONE   = 2'd3
    } gs_state_t;

    localparam int GS_NUM_VEC = 4;
    localparam int GS_TMR_W   = 8;

    // The timer counts SETTLE-1 down to 0, so a vector spends exactly
    // SETTLE cycles in the settle state.
    function automatic logic [GS_TMR_W-1:0] gs_reload_val(input int unsigned settle);
        return GS_TMR_W'(settle - 1);
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// settle_timer
// Loadable down-counter that measures the settle time of each vector.
// It stops at zero and stays there until the next load.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset (count returns to 0)
//   i_load     - load i_load_val on the next rising edge
//   i_load_val - value to load
//   o_zero     - high while the count is zero
module settle_timer
    import gate_sweep_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [GS_TMR_W-1:0] i_load_val,
    output logic                o_zero
);

    logic [GS_TMR_W-1:0] r_count;

    // Load wins over counting; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - GS_TMR_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
// Drives all four input combinations (00, 01, 10, 11) onto an external
// 2-input gate. It waits SETTLE cycles per vector and samples the gate
// output. It builds the observed truth table and compares it with the
// expected table latched at start.
// Parameters:
//   SETTLE    - settle cycles per vector before sampling (1..255)
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   start     - sweep request, level-sampled in idle only
//   expected  - expected truth table, bit index = {a,b}
//   c         - output of the gate under test
//   a, b      - registered gate inputs
//   busy      - high while a sweep is in progress
//   done      - single-cycle completion pulse
//   pass      - captured == expected, valid with done, held until next start
//   captured  - observed truth table, bit index = {a,b}
//   err_count - saturating failed-sweep counter; present only when the
//               macro GATE_SWEEP_ERRCNT_EN is defined
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] captured
`ifdef GATE_SWEEP_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    gs_state_t r_state;
    gs_state_t w_next;
    logic      w_load;
    logic      w_zero;

    logic [1:0] r_index;
    logic [3:0] r_exp;
    logic [3:0] r_captured;
    logic       r_a;
    logic       r_b;
    logic       r_done;
    logic       r_pass;

    settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (gs_reload_val(SETTLE)),
        .o_zero     (w_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= GS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. The timer is reloaded both on an accepted start and
    // when one vector's sample is done and the next vector begins.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            GS_IDLE: begin
                if (start) begin
                    w_next = GS_SETTLE;
                    w_load = 1'b1;
                end
            end
            GS_SETTLE: begin
                if (w_zero) begin
                    w_next = GS_SAMPLE;
                end
            end
            GS_SAMPLE: begin
                if (r_index == 2'd3) begin
                    w_next = GS_DONE;
                end else begin
                    w_next = GS_SETTLE;
                    w_load = 1'b1;
                end
            end
            GS_DONE: begin
                w_next = GS_IDLE;
            end
            default: begin
                w_next = GS_IDLE;
            end
        endcase
    end

    // Vector index, gate inputs, capture and compare.
    // The gate inputs change on the same edge as the index, so the gate sees
    // each vector for the whole SETTLE+SAMPLE window. The inputs return to 00
    // once the last sample is taken. The done pulse and the pass verdict are
    // both registered out of the DONE state, so they appear on the edge that
    // leaves DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index    <= 2'd0;
            r_exp      <= 4'd0;
            r_captured <= 4'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_done <= (r_state == GS_DONE);
            case (r_state)
                GS_IDLE: begin
                    if (start) begin
                        r_exp      <= expected;
                        r_captured <= 4'd0;
                        r_pass     <= 1'b0;
                        r_index    <= 2'd0;
                        {r_a, r_b} <= 2'b00;
                    end
                end
                GS_SAMPLE: begin
                    r_captured[r_index] <= c;
                    if (r_index == 2'd3) begin
                        {r_a, r_b} <= 2'b00;
                    end else begin
                        r_index    <= r_index + 2'd1;
                        {r_a, r_b} <= r_index + 2'd1;
                    end
                end
                GS_DONE: begin
                    r_pass <= (r_captured == r_exp);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GATE_SWEEP_ERRCNT_EN
    logic [7:0] r_errCount;

    // Failed-sweep counter: counts mismatching sweeps and saturates at 255.
    // A start does not clear it; only reset does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errCount <= 8'd0;
        end else if ((r_state == GS_DONE) && (r_captured != r_exp) && (r_errCount != 8'hFF)) begin
            r_errCount <= r_errCount + 8'd1;
        end
    end

    assign err_count = r_errCount;
`endif

    assign a        = r_a;
    assign b        = r_b;
    assign busy     = (r_state == GS_SETTLE) || (r_state == GS_SAMPLE);
    assign done     = r_done;
    assign pass     = r_pass;
    assign captured = r_captured;

endmodule
